miso_word_receiver: RTL and testbench

//  Return path of the RHD2000 SPI link: deserialises the 16-bit MISO result of each command frame.

---
 rtl/miso_word_receiver_if.sv | 22 ++
 rtl/miso_word_receiver.sv | 104 ++++++++++
 tb/tb_miso_word_receiver.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/miso_word_receiver_if.sv
// miso_word_receiver_if: MISO return-path signals between the SPI frame logic and the word receiver.
interface miso_word_receiver_if #(parameter int DELAY_W = 4);
  logic cs_b;
  logic sclk_strobe;
  logic miso;
  logic [5:0] channel;
  logic [DELAY_W-1:0] delay_cfg;
  logic [15:0] word_out;
  logic [5:0] word_chan;
  logic word_is_aux;
  logic word_valid;
  logic frame_err;
  logic intan_id_ok;
  modport master (
    output cs_b, sclk_strobe, miso, channel, delay_cfg,
    input word_out, word_chan, word_is_aux, word_valid, frame_err, intan_id_ok
  );
  modport slave (
    input cs_b, sclk_strobe, miso, channel, delay_cfg,
    output word_out, word_chan, word_is_aux, word_valid, frame_err, intan_id_ok
  );
endinterface

// File: rtl/miso_word_receiver.sv
// miso_word_receiver: delay-compensated 16-bit MISO deserialiser with two-frame channel re-tagging.
// Define INTAN_CHECK_EN to build the sticky 'INTAN' chip-ID matcher on aux words.
module miso_word_receiver #(
  parameter int MAX_DELAY = 15,
  parameter int DELAY_W = 4
) (
  input logic dataclk,
  input logic reset_n,
  miso_word_receiver_if.slave bus
);
  localparam int IW = MAX_DELAY > 1 ? $clog2(MAX_DELAY + 1) : 1;
  logic cs_q;
  logic [MAX_DELAY-1:0] stb_line, bit_line;
  logic [MAX_DELAY:0] stb_tap, bit_tap;
  logic [IW-1:0] eff;
  logic samp, sbit, frame_start, done, abort;
  logic [3:0] cnt;
  logic [14:0] shreg;
  logic [5:0] tag0, tag1, tag2, wtag;
  logic v0, v1, v2, wtag_v;
  logic [15:0] word_q;
  logic [5:0] chan_q;
  logic aux_q, valid_q, err_q, ok_q;
  // Tap 0 is the live strobe/bit, so a delay of 0 samples in the strobe cycle itself.
  assign stb_tap = {stb_line, bus.sclk_strobe};
  assign bit_tap = {bit_line, bus.miso};
  assign eff = bus.delay_cfg > DELAY_W'(MAX_DELAY) ? IW'(MAX_DELAY) : IW'(bus.delay_cfg);
  assign samp = stb_tap[eff];
  assign sbit = bit_tap[eff];
  assign frame_start = cs_q & ~bus.cs_b;
  assign done = samp & (cnt == 4'd15);
  assign abort = frame_start & ~done & (cnt != 4'd0);
  always_ff @(posedge dataclk or negedge reset_n) begin
    if (!reset_n) begin
      cs_q <= 1'b0;
      stb_line <= '0;
      bit_line <= '0;
      cnt <= 4'd0;
      shreg <= '0;
      {tag0, tag1, tag2, wtag} <= '0;
      {v0, v1, v2, wtag_v} <= '0;
      word_q <= '0;
      chan_q <= '0;
      aux_q <= 1'b0;
      valid_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      cs_q <= bus.cs_b;
      stb_line <= stb_tap[MAX_DELAY-1:0];
      bit_line <= bit_tap[MAX_DELAY-1:0];
      valid_q <= done & wtag_v;
      err_q <= abort;
      if (frame_start) begin
        {tag2, tag1, tag0} <= {tag1, tag0, bus.channel};
        {v2, v1, v0} <= {v1, v0, 1'b1};
      end
      if (done) begin
        word_q <= {shreg, sbit};
        chan_q <= wtag;
        aux_q <= wtag >= 6'd32 && wtag <= 6'd34;
      end
      if (abort) cnt <= 4'd0;
      else if (samp) begin
        cnt <= cnt + 4'd1;
        shreg <= {shreg[13:0], sbit};
        if (cnt == 4'd0) {wtag, wtag_v} <= {tag2, v2};
      end
    end
  end
`ifdef INTAN_CHECK_EN
  typedef enum logic [2:0] {M_I, M_N, M_T, M_A, M_N2} m_t;
  m_t m_q, m_d;
  logic ok_d;
  logic [7:0] exp_b;
  always_ff @(posedge dataclk or negedge reset_n) begin
    if (!reset_n) begin
      m_q <= M_I;
      ok_q <= 1'b0;
    end else begin
      m_q <= m_d;
      ok_q <= ok_d;
    end
  end
  always_comb begin
    exp_b = m_q == M_I ? "I" : m_q == M_N ? "N" : m_q == M_T ? "T" : m_q == M_A ? "A" : "N";
    m_d = m_q;
    ok_d = ok_q;
    if (valid_q & aux_q) begin
      if (word_q[7:0] == exp_b) begin
        m_d = m_q == M_N2 ? M_I : m_t'(m_q + 3'd1);
        ok_d = ok_q | (m_q == M_N2);
      end else m_d = word_q[7:0] == "I" ? M_N : M_I;
    end
  end
`else
  assign ok_q = 1'b0;
`endif
  assign bus.word_out = word_q;
  assign bus.word_chan = chan_q;
  assign bus.word_is_aux = aux_q;
  assign bus.word_valid = valid_q;
  assign bus.frame_err = err_q;
  assign bus.intan_id_ok = ok_q;
endmodule

// File: tb/tb_miso_word_receiver.sv
// tb_miso_word_receiver: directed frames against a 4-bit and a 5-bit delay_cfg build of the receiver.
module tb_miso_word_receiver;
  logic dataclk = 1'b0;
  logic reset_n = 1'b0;
  int vec = 0, bad = 0, cyc = 0, last_stb = 0;
  int vcyc0 = 0, vcyc1 = 0, ecnt0 = 0, okcyc = -1;
  logic [15:0] wq0[$], wq1[$];
  logic [5:0] cq0[$];
  logic aq0[$];
  miso_word_receiver_if b ();
  miso_word_receiver_if #(.DELAY_W(5)) b5 ();
  miso_word_receiver u0 (.dataclk(dataclk), .reset_n(reset_n), .bus(b));
  miso_word_receiver #(.MAX_DELAY(15), .DELAY_W(5)) u1 (.dataclk(dataclk), .reset_n(reset_n), .bus(b5));
  assign b5.cs_b = b.cs_b;
  assign b5.sclk_strobe = b.sclk_strobe;
  assign b5.miso = b.miso;
  assign b5.channel = b.channel;
  always #5 dataclk = ~dataclk;
  always @(posedge dataclk) cyc++;
  always @(negedge dataclk) begin
    if (b.word_valid) begin
      wq0.push_back(b.word_out);
      cq0.push_back(b.word_chan);
      aq0.push_back(b.word_is_aux);
      vcyc0 = cyc;
    end
    if (b5.word_valid) begin
      wq1.push_back(b5.word_out);
      vcyc1 = cyc;
    end
    if (b.frame_err) ecnt0++;
    if (b.intan_id_ok && okcyc < 0) okcyc = cyc;
  end
  task automatic tick;
    @(posedge dataclk);
    #1;
  endtask
  // Bits are 32 cycles wide with the strobe mid-bit, so MISO lag up to 15 cycles still lands inside the bit.
  task automatic send_frame(input logic [5:0] ch, input logic [15:0] w, input int lag, input int nbits,
                            input int len, input int gap, input bit keep_low);
    b.cs_b = 1'b0;
    b.channel = ch;
    for (int t = 0; t < len; t++) begin
      b.sclk_strobe = (t % 32 == 16) && (t / 32 < nbits);
      if (b.sclk_strobe) last_stb = cyc;
      if (t >= lag && (t - lag) / 32 < 16) b.miso = w[15 - (t - lag) / 32];
      tick();
    end
    b.sclk_strobe = 1'b0;
    if (!keep_low) begin
      b.cs_b = 1'b1;
      repeat (gap) tick();
    end
  endtask
  task automatic frame(input logic [5:0] ch, input logic [15:0] w, input int lag);
    send_frame(ch, w, lag, 16, 512, 40, 1'b0);
  endtask
  task automatic test_reset;
    b.cs_b = 1'b1; b.sclk_strobe = 1'b0; b.miso = 1'b0; b.channel = '0; b.delay_cfg = '0; b5.delay_cfg = '0;
    repeat (3) tick();
    vec++; if (b.word_out !== 16'h0) begin bad++; $display("FAIL reset_word got %h want 0000", b.word_out); end
    vec++; if (b.word_chan !== 6'd0) begin bad++; $display("FAIL reset_chan got %0d want 0", b.word_chan); end
    vec++; if (b.word_is_aux !== 1'b0) begin bad++; $display("FAIL reset_aux got %b want 0", b.word_is_aux); end
    vec++; if (b.word_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got %b want 0", b.word_valid); end
    vec++; if (b.frame_err !== 1'b0) begin bad++; $display("FAIL reset_err got %b want 0", b.frame_err); end
    vec++; if (b.intan_id_ok !== 1'b0) begin bad++; $display("FAIL reset_ok got %b want 0", b.intan_id_ok); end
    reset_n = 1'b1;
    repeat (2) tick();
  endtask
  task automatic test_basic;
    int n = wq0.size();
    frame(6'd5, 16'hA5A5, 0);
    frame(6'd6, 16'h1234, 0);
    vec++; if (wq0.size() - n !== 0) begin bad++; $display("FAIL basic_drop got %0d words want 0", wq0.size() - n); end
    frame(6'd7, 16'hBEEF, 0);
    vec++; if (wq0.size() - n !== 1) begin bad++; $display("FAIL basic_count got %0d want 1", wq0.size() - n); end
    vec++; if (wq0[$] !== 16'hBEEF) begin bad++; $display("FAIL basic_word got %h want beef", wq0[$]); end
    vec++; if (cq0[$] !== 6'd5) begin bad++; $display("FAIL basic_chan got %0d want 5", cq0[$]); end
    vec++; if (aq0[$] !== 1'b0) begin bad++; $display("FAIL basic_aux got %b want 0", aq0[$]); end
    vec++; if (vcyc0 - last_stb !== 1) begin bad++; $display("FAIL basic_latency got %0d want 1", vcyc0 - last_stb); end
    vec++; if (ecnt0 !== 0) begin bad++; $display("FAIL basic_err got %0d want 0", ecnt0); end
  endtask
  task automatic test_delay;
    b.delay_cfg = 4'd7; b5.delay_cfg = 5'd7;
    frame(6'd8, 16'hA5A5, 7);
    vec++; if (wq0[$] !== 16'hA5A5) begin bad++; $display("FAIL delay_word1 got %h want a5a5", wq0[$]); end
    vec++; if (cq0[$] !== 6'd6) begin bad++; $display("FAIL delay_chan1 got %0d want 6", cq0[$]); end
    vec++; if (vcyc0 - last_stb !== 8) begin bad++; $display("FAIL delay_latency1 got %0d want 8", vcyc0 - last_stb); end
    frame(6'd9, 16'h1234, 7);
    vec++; if (wq0[$] !== 16'h1234) begin bad++; $display("FAIL delay_word2 got %h want 1234", wq0[$]); end
    vec++; if (cq0[$] !== 6'd7) begin bad++; $display("FAIL delay_chan2 got %0d want 7", cq0[$]); end
    frame(6'd10, 16'hBEEF, 7);
    vec++; if (wq0[$] !== 16'hBEEF) begin bad++; $display("FAIL delay_word3 got %h want beef", wq0[$]); end
    vec++; if (cq0[$] !== 6'd8) begin bad++; $display("FAIL delay_chan3 got %0d want 8", cq0[$]); end
    vec++; if (vcyc0 - last_stb !== 8) begin bad++; $display("FAIL delay_latency3 got %0d want 8", vcyc0 - last_stb); end
  endtask
  task automatic test_clamp;
    int n0 = wq0.size();
    int n1 = wq1.size();
    b.delay_cfg = 4'hF; b5.delay_cfg = 5'd20;
    frame(6'd11, 16'h0F0F, 15);
    vec++; if (wq0.size() - n0 !== 1) begin bad++; $display("FAIL clamp_count4 got %0d want 1", wq0.size() - n0); end
    vec++; if (wq0[$] !== 16'h0F0F) begin bad++; $display("FAIL clamp_word4 got %h want 0f0f", wq0[$]); end
    vec++; if (cq0[$] !== 6'd9) begin bad++; $display("FAIL clamp_chan4 got %0d want 9", cq0[$]); end
    vec++; if (vcyc0 - last_stb !== 16) begin bad++; $display("FAIL clamp_latency4 got %0d want 16", vcyc0 - last_stb); end
    vec++; if (wq1.size() - n1 !== 1) begin bad++; $display("FAIL clamp_count5 got %0d want 1", wq1.size() - n1); end
    vec++; if (wq1[$] !== 16'h0F0F) begin bad++; $display("FAIL clamp_word5 got %h want 0f0f", wq1[$]); end
    vec++; if (vcyc1 - last_stb !== 16) begin bad++; $display("FAIL clamp_latency5 got %0d want 16", vcyc1 - last_stb); end
  endtask
  task automatic test_abort;
    int n = wq0.size();
    int e = ecnt0;
    b.delay_cfg = 4'd0; b5.delay_cfg = 5'd0;
    send_frame(6'd12, 16'hFFFF, 0, 9, 512, 40, 1'b0);
    vec++; if (wq0.size() - n !== 0) begin bad++; $display("FAIL abort_noword got %0d want 0", wq0.size() - n); end
    vec++; if (ecnt0 - e !== 0) begin bad++; $display("FAIL abort_early_err got %0d want 0", ecnt0 - e); end
    frame(6'd13, 16'hC3C3, 0);
    vec++; if (ecnt0 - e !== 1) begin bad++; $display("FAIL abort_err got %0d want 1", ecnt0 - e); end
    vec++; if (wq0.size() - n !== 1) begin bad++; $display("FAIL abort_count got %0d want 1", wq0.size() - n); end
    vec++; if (wq0[$] !== 16'hC3C3) begin bad++; $display("FAIL abort_word got %h want c3c3", wq0[$]); end
    vec++; if (cq0[$] !== 6'd11) begin bad++; $display("FAIL abort_chan got %0d want 11", cq0[$]); end
  endtask
  // With delay 3 the 16th sample of frame 14 lands exactly on the frame-start cycle of frame 15.
  task automatic test_back_to_back;
    int n = wq0.size();
    int e = ecnt0;
    b.delay_cfg = 4'd3; b5.delay_cfg = 5'd3;
    send_frame(6'd14, 16'h8001, 0, 16, 498, 1, 1'b0);
    frame(6'd15, 16'h7FFE, 0);
    vec++; if (ecnt0 - e !== 0) begin bad++; $display("FAIL b2b_err got %0d want 0", ecnt0 - e); end
    vec++; if (wq0.size() - n !== 2) begin bad++; $display("FAIL b2b_count got %0d want 2", wq0.size() - n); end
    vec++; if (wq0[n] !== 16'h8001) begin bad++; $display("FAIL b2b_word1 got %h want 8001", wq0[n]); end
    vec++; if (cq0[n] !== 6'd12) begin bad++; $display("FAIL b2b_chan1 got %0d want 12", cq0[n]); end
    vec++; if (wq0[n+1] !== 16'h7FFE) begin bad++; $display("FAIL b2b_word2 got %h want 7ffe", wq0[n+1]); end
    vec++; if (cq0[n+1] !== 6'd13) begin bad++; $display("FAIL b2b_chan2 got %0d want 13", cq0[n+1]); end
  endtask
  task automatic test_aux;
    int n = wq0.size();
    logic [5:0] chs[6] = '{6'd32, 6'd33, 6'd34, 6'd35, 6'd0, 6'd0};
    logic [5:0] ec[6] = '{6'd14, 6'd15, 6'd32, 6'd33, 6'd34, 6'd35};
    logic ea[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    b.delay_cfg = 4'd0; b5.delay_cfg = 5'd0;
    for (int i = 0; i < 6; i++) frame(chs[i], 16'h1111 * 16'(i + 1), 0);
    for (int i = 0; i < 6; i++) begin
      vec++; if (cq0[n+i] !== ec[i]) begin bad++; $display("FAIL aux_chan%0d got %0d want %0d", i, cq0[n+i], ec[i]); end
      vec++; if (aq0[n+i] !== ea[i]) begin bad++; $display("FAIL aux_flag%0d got %b want %b", i, aq0[n+i], ea[i]); end
    end
  endtask
  task automatic test_intan;
    logic [7:0] s1[8] = '{"I", "N", "I", "I", "N", "T", "A", "N"};
    logic [7:0] s2[8] = '{"I", "N", "I", "N", "X", "T", "A", "N"};
    logic exp_ok;
    int n;
`ifdef INTAN_CHECK_EN
    exp_ok = 1'b1;
`else
    exp_ok = 1'b0;
`endif
    for (int i = 0; i < 7; i++) frame(i < 6 ? 6'd32 : 6'd0, {8'hA0, s1[i]}, 0);
    vec++; if (b.intan_id_ok !== 1'b0) begin bad++; $display("FAIL intan_early got %b want 0", b.intan_id_ok); end
    frame(6'd0, {8'hA0, s1[7]}, 0);
    vec++; if (b.intan_id_ok !== exp_ok) begin bad++; $display("FAIL intan_ok got %b want %b", b.intan_id_ok, exp_ok); end
`ifdef INTAN_CHECK_EN
    vec++; if (okcyc - vcyc0 !== 1) begin bad++; $display("FAIL intan_rise got %0d want 1", okcyc - vcyc0); end
`endif
    send_frame(6'd32, 16'hFFFF, 0, 9, 300, 0, 1'b1);
    #3 reset_n = 1'b0;
    #2;
    vec++; if (b.word_out !== 16'h0) begin bad++; $display("FAIL rst_mid_word got %h want 0000", b.word_out); end
    vec++; if (b.word_chan !== 6'd0) begin bad++; $display("FAIL rst_mid_chan got %0d want 0", b.word_chan); end
    vec++; if (b.word_is_aux !== 1'b0) begin bad++; $display("FAIL rst_mid_aux got %b want 0", b.word_is_aux); end
    vec++; if (b.word_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid got %b want 0", b.word_valid); end
    vec++; if (b.frame_err !== 1'b0) begin bad++; $display("FAIL rst_mid_err got %b want 0", b.frame_err); end
    vec++; if (b.intan_id_ok !== 1'b0) begin bad++; $display("FAIL rst_mid_ok got %b want 0", b.intan_id_ok); end
    b.cs_b = 1'b1;
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (2) tick();
    okcyc = -1;
    n = wq0.size();
    for (int i = 0; i < 8; i++) frame(6'd32, {8'hA0, s2[i]}, 0);
    vec++; if (wq0.size() - n !== 6) begin bad++; $display("FAIL post_rst_count got %0d want 6", wq0.size() - n); end
    vec++; if (cq0[$] !== 6'd32) begin bad++; $display("FAIL post_rst_chan got %0d want 32", cq0[$]); end
    vec++; if (b.intan_id_ok !== 1'b0) begin bad++; $display("FAIL intan_bad_seq got %b want 0", b.intan_id_ok); end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_delay();
    test_clamp();
    test_abort();
    test_back_to_back();
    test_aux();
    test_intan();
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
